jsoc_multi_timer: RTL

//  Parametrised multi-channel interval timer on a 16-bit Avalon-MM slave for the JSoc Nios II system.
//  - NUM_CH independent down-counters of COUNTER_W bits.
//  - Each channel has a programmable prescaler, one-shot/continuous mode, snapshot and maskable IRQ.
//  - Per-channel IRQs are exposed as a vector and ORed onto irq.
//  - Also provides a one-cycle timeout pulse per channel for hardware triggering (e.g. CRC DMA pacing).

---
 rtl/jsoc_timer_pkg.sv | 22 ++
 rtl/jsoc_timer_channel.sv | 121 ++++++++++++
 rtl/jsoc_multi_timer.sv | 72 +++++++
 3 files changed

// File: rtl/jsoc_timer_pkg.sv
// Shared register map and CONTROL bit positions for the JSoc multi-channel timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jsoc_timer_pkg;

  // Per-channel register offsets (low 3 address bits)
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam logic [2:0] REG_RSVD     = 3'd7;

  // CONTROL register bit indices
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

endpackage

// File: rtl/jsoc_timer_channel.sv
// One timer channel: prescaled down-counter with period, snapshot, run control and timeout flag.
// Latency: register writes take effect on the next clock; period writes reload the counter one clock later.
// Backpressure: none; every write strobe is accepted in its cycle.
module jsoc_timer_channel #(
  parameter int COUNTER_W      = 32,
  parameter int PRESCALE_W     = 8,
  parameter int DEFAULT_PERIOD = 9999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       wr_stb,
  input  logic [15:0]      wdata,
  output logic [7:0][15:0] rd_regs,
  output logic             irq,
  output logic             timeout_pulse
);
  import jsoc_timer_pkg::*;

  logic [COUNTER_W-1:0]  period;
  logic [COUNTER_W-1:0]  counter;
  logic [COUNTER_W-1:0]  snapshot;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [3:0]            control;
  logic                  run;
  logic                  to;
  logic                  force_reload;
  logic                  zero_d1;

  logic wr_status, wr_control, wr_period, wr_snap, wr_prescale;
  logic start, stop, tick, is_zero, one_shot_done, timeout_evt;

  assign wr_status   = wr_stb[REG_STATUS];
  assign wr_control  = wr_stb[REG_CONTROL];
  assign wr_period   = wr_stb[REG_PERIOD_L] | wr_stb[REG_PERIOD_H];
  assign wr_snap     = wr_stb[REG_SNAP_L] | wr_stb[REG_SNAP_H];
  assign wr_prescale = wr_stb[REG_PRESCALE];

  assign start = wr_control & wdata[CTRL_START];
  assign stop  = wr_control & wdata[CTRL_STOP];

  assign is_zero       = (counter == '0);
  assign tick          = run && (pre_cnt == prescale);
  // One-shot halts the moment the counter sits at zero, so it never reloads
  assign one_shot_done = run && is_zero && !control[CTRL_CONT];
  // Rising edge of zero only: a counter parked at zero raises a single event
  assign timeout_evt   = is_zero & ~zero_d1;

  // Software-visible configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period   <= COUNTER_W'(DEFAULT_PERIOD);
      prescale <= '0;
      control  <= '0;
      snapshot <= '0;
    end else begin
      if (wr_stb[REG_PERIOD_L]) period[15:0] <= wdata;
      if (wr_stb[REG_PERIOD_H]) period[COUNTER_W-1:16] <= wdata[COUNTER_W-17:0];
      if (wr_prescale)          prescale <= wdata[PRESCALE_W-1:0];
      if (wr_control)           control  <= wdata[3:0];
      // Captures the value held this cycle, ahead of this cycle's decrement
      if (wr_snap)              snapshot <= counter;
    end
  end

  // Prescaler, counter and run state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      force_reload <= 1'b0;
      pre_cnt      <= '0;
      counter      <= COUNTER_W'(DEFAULT_PERIOD);
      run          <= 1'b0;
    end else begin
      force_reload <= wr_period;

      if (force_reload || start) pre_cnt <= '0;
      else if (tick)             pre_cnt <= '0;
      else if (run)              pre_cnt <= pre_cnt + PRESCALE_W'(1);

      if (force_reload)            counter <= period;
      else if (one_shot_done)      counter <= counter;
      else if (tick && is_zero)    counter <= period;
      else if (tick)               counter <= counter - COUNTER_W'(1);

      if (force_reload)       run <= 1'b0;
      else if (start)         run <= 1'b1;
      else if (stop)          run <= 1'b0;
      else if (one_shot_done) run <= 1'b0;
    end
  end

  // Timeout edge detect, sticky flag and one-cycle pulse; a STATUS write beats a new event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_d1       <= 1'b0;
      to            <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      zero_d1       <= is_zero;
      timeout_pulse <= timeout_evt;
      if (wr_status)        to <= 1'b0;
      else if (timeout_evt) to <= 1'b1;
    end
  end

  assign irq = to & control[CTRL_ITO];

  // Read values per register offset
  always_comb begin
    rd_regs               = '0;
    rd_regs[REG_STATUS]   = {14'd0, run, to};
    rd_regs[REG_CONTROL]  = {12'd0, control};
    rd_regs[REG_PERIOD_L] = period[15:0];
    rd_regs[REG_PERIOD_H] = 16'(period[COUNTER_W-1:16]);
    rd_regs[REG_SNAP_L]   = snapshot[15:0];
    rd_regs[REG_SNAP_H]   = 16'(snapshot[COUNTER_W-1:16]);
    rd_regs[REG_PRESCALE] = 16'(prescale);
    rd_regs[REG_RSVD]     = '0;
  end

endmodule

// File: rtl/jsoc_multi_timer.sv
// Multi-channel interval timer on a 16-bit Avalon-MM slave: address decode, read mux, irq merge.
// Latency: readdata is registered, valid one clock after address.
// Backpressure: none; the slave never stalls.
module jsoc_multi_timer #(
  parameter int NUM_CH         = 2,
  parameter int COUNTER_W      = 32,
  parameter int PRESCALE_W     = 8,
  parameter int DEFAULT_PERIOD = 9999
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          chipselect,
  input  logic [3+$clog2(NUM_CH)-1:0]   address,
  input  logic                          write_n,
  input  logic [15:0]                   writedata,
  output logic [15:0]                   readdata,
  output logic                          irq,
  output logic [NUM_CH-1:0]             irq_vec,
  output logic [NUM_CH-1:0]             timeout_pulse
);
  import jsoc_timer_pkg::*;

  localparam int AW = 3 + $clog2(NUM_CH);

  logic [2:0]                   reg_sel;
  logic [AW-1:0]                ch_sel;
  logic                         wr;
  logic [7:0]                   reg_onehot;
  logic [NUM_CH-1:0][7:0][15:0] rd_regs;
  logic [15:0]                  rd_mux;

  assign reg_sel    = address[2:0];
  assign ch_sel     = address >> 3;
  assign wr         = chipselect & ~write_n;
  assign reg_onehot = 8'b1 << reg_sel;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    logic [7:0] wr_stb;
    assign wr_stb = (wr && (ch_sel == AW'(g))) ? reg_onehot : 8'd0;

    jsoc_timer_channel #(
      .COUNTER_W      (COUNTER_W),
      .PRESCALE_W     (PRESCALE_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .wr_stb        (wr_stb),
      .wdata         (writedata),
      .rd_regs       (rd_regs[g]),
      .irq           (irq_vec[g]),
      .timeout_pulse (timeout_pulse[g])
    );
  end

  // Address mux; channel indices with no channel behind them read as zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == AW'(i)) rd_mux = rd_regs[i][reg_sel];
    end
  end

  // Read data registered every cycle, independent of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |irq_vec;

endmodule
